// File: rtl/tick_period_meter.sv
// Measures the spacing in clk cycles between successive rising edges of tick_in and
// hands each result to a consumer over a valid/ready port, flagging overflow and drops.
module tick_period_meter #(
  parameter int unsigned MAX_PERIOD  = 255,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                enable,
  input  logic                                tick_in,
  output logic [$clog2(MAX_PERIOD + 1)-1:0]   period,
  output logic                                overflow,
  output logic                                period_valid,
  input  logic                                period_ready,
  output logic                                missed,
  output logic                                busy
);

  localparam int unsigned BITS = $clog2(MAX_PERIOD + 1);
  localparam logic [BITS-1:0] MaxCnt = BITS'(MAX_PERIOD);

  typedef enum logic [1:0] {StIdle, StWaitFirst, StMeasure} state_e;

  state_e                 state_q, state_d;
  logic [BITS-1:0]        cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tick_edge;

  logic                   new_res;
  logic [BITS-1:0]        new_period;
  logic                   new_ovf;

  logic [BITS-1:0]        period_q, period_d;
  logic                   overflow_q, overflow_d;
  logic                   valid_q, valid_d;
  logic                   missed_q, missed_d;

  // Front end runs regardless of enable so a level held across enable toggles gives one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    new_res    = 1'b0;
    new_period = '0;
    new_ovf    = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d   = '0;
          state_d = StWaitFirst;
        end
        StWaitFirst: begin
          if (tick_edge) begin
            cnt_d   = BITS'(1);
            state_d = StMeasure;
          end
        end
        StMeasure: begin
          if (tick_edge) begin
            new_res    = 1'b1;
            new_period = cnt_q;
            cnt_d      = BITS'(1);
          end else if (cnt_q == MaxCnt) begin
            // No edge within MAX_PERIOD cycles: report saturation and re-arm.
            new_res    = 1'b1;
            new_period = MaxCnt;
            new_ovf    = 1'b1;
            cnt_d      = '0;
            state_d    = StWaitFirst;
          end else begin
            cnt_d = cnt_q + BITS'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Result register: an accept frees the slot for a same-cycle result; otherwise a full slot drops it.
  always_comb begin
    period_d   = period_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    missed_d   = 1'b0;
    if (new_res && (!valid_q || period_ready)) begin
      period_d   = new_period;
      overflow_d = new_ovf;
      valid_d    = 1'b1;
    end else if (new_res) begin
      missed_d = 1'b1;
    end else if (valid_q && period_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      period_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      missed_q   <= missed_d;
    end
  end

  assign period       = period_q;
  assign overflow     = overflow_q;
  assign period_valid = valid_q;
  assign missed       = missed_q;
  assign busy         = (state_q == StMeasure);

endmodule
